ht_cmd_issue: RTL and testbench

Command-issue front end for the hash table pipeline; the initiator side of the ht_if command stream that the bucket-hash stage consumes. Accepts search/insert/delete requests on a flat valid/ready port and buffers them in a FIFO. Drives them as an ht_if master, with an in-flight credit limit released by result completions. Sits between the host/CSR bridge and the hash calculation stage.

---
 rtl/ht_cmd_issue_if.sv | 27 ++
 rtl/ht_cmd_issue.sv | 234 +++++++++++++++++++++++
 tb/tb_ht_cmd_issue.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ht_cmd_issue_if.sv
// ht_if: command stream between the hash-table command issuer and the bucket-hash stage.
// The master drives the command fields and valid; the slave returns ready.
interface ht_if #(
    parameter int unsigned KEY_WIDTH        = 32,
    parameter int unsigned VALUE_WIDTH      = 16,
    parameter int unsigned BUCKET_WIDTH     = 8,
    parameter int unsigned TABLE_ADDR_WIDTH = 10
);
    logic                        valid;
    logic                        ready;
    logic [1:0]                  cmd;
    logic [KEY_WIDTH-1:0]        key;
    logic [VALUE_WIDTH-1:0]      value;
    logic [BUCKET_WIDTH-1:0]     bucket;
    logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
    logic                        head_ptr_val;

    modport master (
        output valid, cmd, key, value, bucket, head_ptr, head_ptr_val,
        input  ready
    );

    modport slave (
        input  valid, cmd, key, value, bucket, head_ptr, head_ptr_val,
        output ready
    );
endinterface

// File: rtl/ht_cmd_issue.sv
// ht_cmd_issue: buffers search/insert/delete requests and issues them on ht_if under a credit limit.
// Define HT_CMD_ISSUE_STATS_EN to add per-command transfer counters and stat_clr_i.
module ht_cmd_issue #(
    parameter int unsigned KEY_WIDTH        = 32,
    parameter int unsigned VALUE_WIDTH      = 16,
    parameter int unsigned BUCKET_WIDTH     = 8,
    parameter int unsigned TABLE_ADDR_WIDTH = 10,
    parameter int unsigned FIFO_DEPTH       = 8,
    parameter int unsigned MAX_INFLIGHT     = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [1:0]                    req_cmd_i,
    input  logic [KEY_WIDTH-1:0]          req_key_i,
    input  logic [VALUE_WIDTH-1:0]        req_value_i,
    input  logic                          flush_i,
    input  logic                          res_done_i,
    ht_if.master                          ht_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_used_o,
    output logic [$clog2(MAX_INFLIGHT):0] inflight_o,
    output logic [15:0]                   drop_cnt_o,
`ifdef HT_CMD_ISSUE_STATS_EN
    input  logic                          stat_clr_i,
    output logic [31:0]                   stat_search_o,
    output logic [31:0]                   stat_insert_o,
    output logic [31:0]                   stat_delete_o,
`endif
    output logic                          busy_o
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned USED_W = PTR_W + 1;
    localparam int unsigned CNT_W  = $clog2(MAX_INFLIGHT) + 1;

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_FLUSH = 1'b1;

    localparam logic [1:0] CMD_ILLEGAL = 2'd3;

    typedef struct packed {
        logic [1:0]             cmd;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } entry_t;

    logic              state_q, state_d;
    entry_t            head_q, head_d;
    logic              head_valid_q, head_valid_d;
    entry_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [USED_W-1:0] mem_cnt_q, mem_cnt_d;
    logic [USED_W-1:0] used_q, used_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [15:0]       drop_q, drop_d;
    logic              busy_q;

    logic   run;
    logic   push;
    logic   wr;
    logic   mem_we;
    logic   out_valid;
    logic   pop;
    logic   credit_ret;
    entry_t in_entry;

    assign run        = (state_q == ST_RUN) && !rst_i;
    assign req_ready_o = run && (used_q != USED_W'(FIFO_DEPTH));
    assign push       = req_valid_i && req_ready_o;
    assign wr         = push && (req_cmd_i != CMD_ILLEGAL);
    assign out_valid  = run && head_valid_q && (inflight_q < CNT_W'(MAX_INFLIGHT));
    assign pop        = out_valid && ht_out.ready;
    assign credit_ret = res_done_i && (inflight_q != '0);

    assign in_entry.cmd   = req_cmd_i;
    assign in_entry.key   = req_key_i;
    assign in_entry.value = req_value_i;

    // The head register is the FIFO's output stage; mem only holds entries queued behind it.
    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        head_valid_d = head_valid_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_cnt_d    = mem_cnt_q;
        used_d       = used_q;
        mem_we       = 1'b0;

        if (state_q == ST_FLUSH) begin
            state_d      = ST_RUN;
            head_valid_d = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            mem_cnt_d    = '0;
            used_d       = '0;
        end else begin
            if (flush_i) begin
                state_d = ST_FLUSH;
            end

            if (!head_valid_q || pop) begin
                if (mem_cnt_q != '0) begin
                    head_d       = mem_q[rd_ptr_q];
                    head_valid_d = 1'b1;
                    rd_ptr_d     = rd_ptr_q + PTR_W'(1);
                    mem_cnt_d    = mem_cnt_q - USED_W'(1);
                    if (wr) begin
                        mem_we    = 1'b1;
                        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                        mem_cnt_d = mem_cnt_q;
                    end
                end else if (wr) begin
                    head_d       = in_entry;
                    head_valid_d = 1'b1;
                end else begin
                    head_valid_d = 1'b0;
                end
            end else if (wr) begin
                mem_we    = 1'b1;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                mem_cnt_d = mem_cnt_q + USED_W'(1);
            end

            case ({wr, pop})
                2'b10:   used_d = used_q + USED_W'(1);
                2'b01:   used_d = used_q - USED_W'(1);
                default: used_d = used_q;
            endcase
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({pop, credit_ret})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (push && (req_cmd_i == CMD_ILLEGAL) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RUN;
            head_q       <= '0;
            head_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_cnt_q    <= '0;
            used_q       <= '0;
            inflight_q   <= '0;
            drop_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_cnt_q    <= mem_cnt_d;
            used_q       <= used_d;
            inflight_q   <= inflight_d;
            drop_q       <= drop_d;
            busy_q       <= (used_d != '0) || (inflight_d != '0);
        end
    end

    // Payload storage needs no reset; occupancy is tracked by mem_cnt_q.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    assign ht_out.valid        = out_valid;
    assign ht_out.cmd          = head_q.cmd;
    assign ht_out.key          = head_q.key;
    assign ht_out.value        = head_q.value;
    assign ht_out.bucket       = BUCKET_WIDTH'(0);
    assign ht_out.head_ptr     = TABLE_ADDR_WIDTH'(0);
    assign ht_out.head_ptr_val = 1'b0;

    assign fifo_used_o = used_q;
    assign inflight_o  = inflight_q;
    assign drop_cnt_o  = drop_q;
    assign busy_o      = busy_q;

`ifdef HT_CMD_ISSUE_STATS_EN
    localparam logic [1:0] CMD_SEARCH = 2'd0;
    localparam logic [1:0] CMD_INSERT = 2'd1;
    localparam logic [1:0] CMD_DELETE = 2'd2;

    logic [31:0] stat_search_q;
    logic [31:0] stat_insert_q;
    logic [31:0] stat_delete_q;

    // Clear wins over a same-cycle transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i || stat_clr_i) begin
            stat_search_q <= '0;
            stat_insert_q <= '0;
            stat_delete_q <= '0;
        end else if (pop) begin
            case (head_q.cmd)
                CMD_SEARCH: begin
                    if (stat_search_q != '1) stat_search_q <= stat_search_q + 32'd1;
                end
                CMD_INSERT: begin
                    if (stat_insert_q != '1) stat_insert_q <= stat_insert_q + 32'd1;
                end
                CMD_DELETE: begin
                    if (stat_delete_q != '1) stat_delete_q <= stat_delete_q + 32'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign stat_search_o = stat_search_q;
    assign stat_insert_o = stat_insert_q;
    assign stat_delete_o = stat_delete_q;
`endif

endmodule

// File: tb/tb_ht_cmd_issue.sv
// tb_ht_cmd_issue: directed and randomized checks of ht_cmd_issue against a queue-based model.
module tb_ht_cmd_issue;

    localparam int KW    = 32;
    localparam int VW    = 16;
    localparam int BW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 8;
    localparam int MAXI  = 4;

    typedef struct packed {
        logic [1:0]    cmd;
        logic [KW-1:0] key;
        logic [VW-1:0] value;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_cmd = '0;
    logic [KW-1:0] req_key = '0;
    logic [VW-1:0] req_value = '0;
    logic          flush = 1'b0;
    logic          res_done = 1'b0;
    logic [3:0]    fifo_used;
    logic [2:0]    inflight;
    logic [15:0]   drop_cnt;
    logic          busy;
`ifdef HT_CMD_ISSUE_STATS_EN
    logic          stat_clr = 1'b0;
    logic [31:0]   stat_search, stat_insert, stat_delete;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ht_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .BUCKET_WIDTH(BW), .TABLE_ADDR_WIDTH(AW)) ht ();

    ht_cmd_issue #(
        .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .BUCKET_WIDTH(BW), .TABLE_ADDR_WIDTH(AW),
        .FIFO_DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cmd_i(req_cmd),
        .req_key_i(req_key), .req_value_i(req_value),
        .flush_i(flush), .res_done_i(res_done),
        .ht_out(ht),
        .fifo_used_o(fifo_used), .inflight_o(inflight), .drop_cnt_o(drop_cnt),
`ifdef HT_CMD_ISSUE_STATS_EN
        .stat_clr_i(stat_clr), .stat_search_o(stat_search), .stat_insert_o(stat_insert),
        .stat_delete_o(stat_delete),
`endif
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of pending commands, a credit count and a flush flag.
    cmd_t m_q[$];
    int   m_inflight = 0;
    int   m_drop = 0;
    bit   m_flush = 0;
    cmd_t exp_x[$];
    cmd_t act_x[$];

    function automatic bit exp_ready();
        return !rst && !m_flush && (m_q.size() < DEPTH);
    endfunction

    function automatic bit exp_valid();
        return !rst && !m_flush && (m_q.size() > 0) && (m_inflight < MAXI);
    endfunction

    initial forever begin
        bit   rdy, xfer;
        int   old;
        cmd_t ent;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_inflight = 0;
            m_drop = 0;
            m_flush = 0;
        end else begin
            rdy  = exp_ready();
            xfer = exp_valid() && (ht.ready === 1'b1);
            old  = m_inflight;
            if (xfer) exp_x.push_back(m_q.pop_front());
            if (m_flush) begin
                m_q.delete();
                m_flush = 0;
            end else begin
                if (req_valid && rdy) begin
                    if (req_cmd == 2'd3) begin
                        if (m_drop < 65535) m_drop = m_drop + 1;
                    end else begin
                        ent.cmd = req_cmd;
                        ent.key = req_key;
                        ent.value = req_value;
                        m_q.push_back(ent);
                    end
                end
                if (flush) m_flush = 1;
            end
            m_inflight = old + (xfer ? 1 : 0) - ((res_done && old > 0) ? 1 : 0);
        end
    end

    // Records every DUT transfer, sampled mid-cycle.
    initial forever begin
        cmd_t ent;
        @(negedge clk);
        if (ht.valid === 1'b1 && ht.ready === 1'b1) begin
            ent.cmd = ht.cmd;
            ent.key = ht.key;
            ent.value = ht.value;
            act_x.push_back(ent);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        flush = 1'b0;
        res_done = 1'b0;
        ht.ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        act_x.delete();
        exp_x.delete();
    endtask

    task automatic test_reset();
        step();
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        n_checks++; if (ht.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", ht.valid); end
        rst = 1'b0;
        ht.ready = 1'b0;
        step();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_ready: got %b want 1", req_ready); end
        n_checks++; if (fifo_used !== 4'd0) begin n_fail++; $display("FAIL rst_fifo_used: got %0d want 0", fifo_used); end
        n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("FAIL rst_inflight: got %0d want 0", inflight); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if ({ht.cmd, ht.key, ht.value} !== '0) begin n_fail++; $display("FAIL rst_fields: got %h want 0", {ht.cmd, ht.key, ht.value}); end
        n_checks++; if ({ht.bucket, ht.head_ptr, ht.head_ptr_val} !== '0) begin n_fail++; $display("FAIL rst_tie0: got %h want 0", {ht.bucket, ht.head_ptr, ht.head_ptr_val}); end
    endtask

    task automatic test_single_insert();
        do_reset();
        req_valid = 1'b1; req_cmd = 2'd1; req_key = 32'h0000_00A5; req_value = 16'h1234;
        ht.ready = 1'b1;
        n_checks++; if (ht.valid !== 1'b0) begin n_fail++; $display("FAIL ins_valid_early: got %b want 0", ht.valid); end
        step();
        req_valid = 1'b0;
        n_checks++; if (ht.valid !== 1'b1) begin n_fail++; $display("FAIL ins_valid: got %b want 1", ht.valid); end
        n_checks++; if ({ht.cmd, ht.key, ht.value} !== {2'd1, 32'h0000_00A5, 16'h1234}) begin
            n_fail++; $display("FAIL ins_fields: got %h want %h", {ht.cmd, ht.key, ht.value}, {2'd1, 32'h0000_00A5, 16'h1234}); end
        step();
        n_checks++; if (inflight !== 3'd1) begin n_fail++; $display("FAIL ins_inflight1: got %0d want 1", inflight); end
        n_checks++; if (ht.valid !== 1'b0) begin n_fail++; $display("FAIL ins_valid_after: got %b want 0", ht.valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ins_busy: got %b want 1", busy); end
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("FAIL ins_inflight0: got %0d want 0", inflight); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ins_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_fill_drain();
        logic [KW-1:0] keys [DEPTH];
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            keys[i] = $urandom;
            req_valid = 1'b1; req_cmd = 2'd0; req_key = keys[i]; req_value = 16'($urandom);
            step();
        end
        req_valid = 1'b0;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_req_ready: got %b want 0", req_ready); end
        n_checks++; if (fifo_used !== 4'd8) begin n_fail++; $display("FAIL full_used: got %0d want 8", fifo_used); end
        ht.ready = 1'b1;
        res_done = 1'b1;
        repeat (14) step();
        ht.ready = 1'b0;
        res_done = 1'b0;
        n_checks++; if (act_x.size() != DEPTH) begin n_fail++; $display("FAIL drain_count: got %0d want %0d", act_x.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < act_x.size(); i++) begin
            n_checks++; if (act_x[i].key !== keys[i] || act_x[i].cmd !== 2'd0) begin
                n_fail++; $display("FAIL drain_order[%0d]: got key %h want %h", i, act_x[i].key, keys[i]); end
        end
        n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("FAIL drain_inflight: got %0d want 0", inflight); end
    endtask

    task automatic test_credit();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_cmd = 2'd1; req_key = $urandom; req_value = 16'($urandom);
            step();
        end
        req_valid = 1'b0;
        ht.ready = 1'b1;
        repeat (8) step();
        n_checks++; if (act_x.size() != 4) begin n_fail++; $display("FAIL credit_xfers: got %0d want 4", act_x.size()); end
        n_checks++; if (ht.valid !== 1'b0) begin n_fail++; $display("FAIL credit_valid: got %b want 0", ht.valid); end
        n_checks++; if (inflight !== 3'd4) begin n_fail++; $display("FAIL credit_inflight: got %0d want 4", inflight); end
        n_checks++; if (fifo_used !== 4'd2) begin n_fail++; $display("FAIL credit_used: got %0d want 2", fifo_used); end
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        repeat (4) step();
        n_checks++; if (act_x.size() != 5) begin n_fail++; $display("FAIL credit_one_more: got %0d want 5", act_x.size()); end
        n_checks++; if (inflight !== 3'd4) begin n_fail++; $display("FAIL credit_inflight2: got %0d want 4", inflight); end
        n_checks++; if (act_x.size() == 5 && exp_x.size() == 5 && act_x[4] !== exp_x[4]) begin
            n_fail++; $display("FAIL credit_fifth: got %h want %h", act_x[4], exp_x[4]); end
    endtask

    task automatic test_illegal();
        logic [1:0]    cmds [4];
        logic [KW-1:0] keys [4];
        cmds[0] = 2'd2; cmds[1] = 2'd3; cmds[2] = 2'd3; cmds[3] = 2'd2;
        do_reset();
        ht.ready = 1'b1;
        res_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            keys[i] = $urandom;
            req_valid = 1'b1; req_cmd = cmds[i]; req_key = keys[i]; req_value = 16'($urandom);
            step();
        end
        req_valid = 1'b0;
        repeat (4) step();
        res_done = 1'b0;
        n_checks++; if (act_x.size() != 2) begin n_fail++; $display("FAIL illegal_xfers: got %0d want 2", act_x.size()); end
        n_checks++; if (act_x.size() == 2 && ({act_x[0].cmd, act_x[0].key} !== {2'd2, keys[0]} ||
                                               {act_x[1].cmd, act_x[1].key} !== {2'd2, keys[3]})) begin
            n_fail++; $display("FAIL illegal_keys: got %h %h want %h %h", act_x[0].key, act_x[1].key, keys[0], keys[3]); end
        n_checks++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL illegal_drop: got %0d want 2", drop_cnt); end
    endtask

    task automatic test_flush();
        logic [KW-1:0] k;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_cmd = 2'd0; req_key = $urandom; req_value = 16'($urandom);
            step();
        end
        req_valid = 1'b0;
        n_checks++; if (fifo_used !== 4'd5) begin n_fail++; $display("FAIL flush_pre_used: got %0d want 5", fifo_used); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        ht.ready = 1'b1;
        n_checks++; if (req_ready !== 1'b0 || ht.valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_state: got ready %b valid %b want 0 0", req_ready, ht.valid); end
        step();
        n_checks++; if (fifo_used !== 4'd0) begin n_fail++; $display("FAIL flush_used: got %0d want 0", fifo_used); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_back_run: got %b want 1", req_ready); end
        repeat (3) step();
        n_checks++; if (act_x.size() != 0) begin n_fail++; $display("FAIL flush_no_xfer: got %0d want 0", act_x.size()); end
        k = $urandom;
        req_valid = 1'b1; req_cmd = 2'd1; req_key = k; req_value = 16'h5A5A;
        step();
        req_valid = 1'b0;
        step();
        n_checks++; if (act_x.size() != 1 || act_x[0].key !== k) begin
            n_fail++; $display("FAIL flush_new_req: got %0d xfers want 1 with key %h", act_x.size(), k); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        ht.ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; req_cmd = 2'd0; req_key = $urandom; req_value = 16'($urandom);
            step();
        end
        req_valid = 1'b0;
        repeat (2) step();
        ht.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_cmd = 2'd2; req_key = $urandom; req_value = 16'($urandom);
            step();
        end
        req_valid = 1'b0;
        n_checks++; if (inflight !== 3'd2 || fifo_used !== 4'd3) begin
            n_fail++; $display("FAIL mid_pre: got inflight %0d used %0d want 2 3", inflight, fifo_used); end
        rst = 1'b1;
        step();
        act_x.delete();
        exp_x.delete();
        n_checks++; if ({req_ready, ht.valid, busy} !== 3'b000) begin
            n_fail++; $display("FAIL mid_rst_flags: got %b want 000", {req_ready, ht.valid, busy}); end
        n_checks++; if (fifo_used !== 4'd0 || inflight !== 3'd0 || drop_cnt !== 16'd0) begin
            n_fail++; $display("FAIL mid_rst_counts: got %0d %0d %0d want 0 0 0", fifo_used, inflight, drop_cnt); end
        n_checks++; if ({ht.cmd, ht.key, ht.value} !== '0) begin n_fail++; $display("FAIL mid_rst_fields: got %h want 0", {ht.cmd, ht.key, ht.value}); end
        rst = 1'b0;
        ht.ready = 1'b1;
        repeat (5) step();
        ht.ready = 1'b0;
        n_checks++; if (act_x.size() != 0) begin n_fail++; $display("FAIL mid_stale: got %0d xfers want 0", act_x.size()); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_cmd   = 2'($urandom_range(0, 3));
            req_key   = $urandom;
            req_value = 16'($urandom);
            ht.ready  = ($urandom_range(0, 9) < 6);
            res_done  = ($urandom_range(0, 9) < 3);
            flush     = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            n_checks++; if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", i, req_ready, exp_ready()); end
            n_checks++; if (ht.valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", i, ht.valid, exp_valid()); end
            if (exp_valid()) begin
                n_checks++; if ({ht.cmd, ht.key, ht.value} !== m_q[0]) begin
                    n_fail++; $display("FAIL rnd_head@%0d: got %h want %h", i, {ht.cmd, ht.key, ht.value}, m_q[0]); end
            end
            n_checks++; if (fifo_used !== 4'(m_q.size())) begin n_fail++; $display("FAIL rnd_used@%0d: got %0d want %0d", i, fifo_used, m_q.size()); end
            n_checks++; if (inflight !== 3'(m_inflight)) begin n_fail++; $display("FAIL rnd_inflight@%0d: got %0d want %0d", i, inflight, m_inflight); end
            n_checks++; if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL rnd_drop@%0d: got %0d want %0d", i, drop_cnt, m_drop); end
            n_checks++; if (busy !== (m_q.size() != 0 || m_inflight != 0)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b", i, busy); end
            step();
        end
        req_valid = 1'b0; flush = 1'b0; res_done = 1'b0; ht.ready = 1'b0;
        step();
        n_checks++; if (act_x.size() != exp_x.size()) begin n_fail++; $display("FAIL rnd_xfer_count: got %0d want %0d", act_x.size(), exp_x.size()); end
        for (int k = 0; k < exp_x.size() && k < act_x.size(); k++) begin
            n_checks++; if (act_x[k] !== exp_x[k]) begin n_fail++; $display("FAIL rnd_xfer[%0d]: got %h want %h", k, act_x[k], exp_x[k]); end
        end
    endtask

    initial begin
        ht.ready = 1'b0;
        test_reset();
        test_single_insert();
        test_fill_drain();
        test_credit();
        test_illegal();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
